// File: rtl/grant_lock_fsm_pkg.sv
// grant_pkg: shared types and helpers for the grant lock stage.
//   lock_state_t  - FSM state encoding (IDLE, OWN, GAP)
//   grant_code_t  - 2-bit encoded grant from the priority encoder
//   GC_NONE       - encoder code meaning "no requester"
//   code2onehot() - maps 01/10/11 to 001/010/100, 00 to 000
package grant_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} lock_state_t;

    typedef logic [1:0] grant_code_t;

    localparam grant_code_t GC_NONE = 2'b00;

    function automatic logic [2:0] code2onehot(input grant_code_t code);
        logic [2:0] oh;
        oh = 3'b000;
        case (code)
            2'b01:   oh = 3'b001;
            2'b10:   oh = 3'b010;
            2'b11:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/grant_lock_fsm_if.sv
// grant_lock_fsm_if: signal bundle between the encoder side and the lock stage.
//   grant_code    - encoded grant from the priority encoder (master -> slave)
//   request       - raw 3-bit request vector (master -> slave)
//   gnt_onehot    - registered one-hot grant (slave -> master)
//   owner         - registered owner code, 00 when none (slave -> master)
//   busy          - high while a grant is held or dead cycles run (slave -> master)
//   timeout_pulse - one-cycle pulse on revocation by timeout (slave -> master)
//   grants_total  - saturating grant count (slave -> master)
//   state_dbg     - current FSM state for observation (slave -> master)
// Handshake: there is no ready. A nonzero grant_code is a valid request for
// ownership and is only accepted while the block is idle (busy low); the
// acceptance is visible as gnt_onehot/owner one cycle later. Ownership is
// given up when the owner's request bit drops or the hold limit is reached.
interface grant_lock_fsm_if;
    import grant_pkg::*;

    grant_code_t grant_code;
    logic [2:0]  request;
    logic [2:0]  gnt_onehot;
    grant_code_t owner;
    logic        busy;
    logic        timeout_pulse;
    logic [7:0]  grants_total;
    lock_state_t state_dbg;

    modport master (
        output grant_code, request,
        input  gnt_onehot, owner, busy, timeout_pulse, grants_total, state_dbg
    );

    modport slave (
        input  grant_code, request,
        output gnt_onehot, owner, busy, timeout_pulse, grants_total, state_dbg
    );

endinterface

// File: rtl/grant_lock_fsm_sat_counter.sv
// sat_counter: up-counter that stops at all-ones.
//   clk, rst - clock and asynchronous active-high reset
//   inc      - increment enable, ignored once saturated
//   count    - current value
//   sat      - high when count is all ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/grant_lock_fsm.sv
// grant_lock_fsm: registers the encoder's grant code, locks ownership to one
// requester and holds a one-hot grant until the owner drops its request or
// MAX_HOLD cycles elapse, then idles for GAP_CYCLES before re-arbitrating.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - slave side of grant_lock_fsm_if (grant_code/request in,
//              gnt_onehot/owner/busy/timeout_pulse/grants_total/state_dbg out)
module grant_lock_fsm
    import grant_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    grant_lock_fsm_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       gnt_q;
    grant_code_t      owner_q;
    logic             timeout_q;
    logic             accept;
    logic             owner_req;
    logic             total_sat;

    assign accept = (state == S_IDLE) && (bus.grant_code != GC_NONE);

    // gnt_q is the owner's one-hot, so masking request with it picks out
    // exactly the owner's request bit.
    assign owner_req = |(bus.request & gnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            gnt_q     <= 3'b000;
            owner_q   <= GC_NONE;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_OWN;
                        owner_q  <= bus.grant_code;
                        gnt_q    <= code2onehot(bus.grant_code);
                        hold_cnt <= '0;
                    end
                end
                S_OWN: begin
                    // Release takes precedence over timeout.
                    if (!owner_req) begin
                        state   <= S_GAP;
                        gnt_q   <= 3'b000;
                        owner_q <= GC_NONE;
                        gap_cnt <= '0;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state     <= S_GAP;
                        gnt_q     <= 3'b000;
                        owner_q   <= GC_NONE;
                        gap_cnt   <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    gnt_q   <= 3'b000;
                    owner_q <= GC_NONE;
                end
            endcase
        end
    end

    sat_counter #(.W(8)) u_grants_total (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (bus.grants_total),
        .sat   (total_sat)
    );

    assign bus.gnt_onehot    = gnt_q;
    assign bus.owner         = owner_q;
    assign bus.busy          = (state != S_IDLE);
    assign bus.timeout_pulse = timeout_q;
    assign bus.state_dbg     = lock_state_t'(state);

endmodule

// File: tb/tb_grant_lock_fsm.sv
// tb_grant_lock_fsm: directed scenarios plus random traffic for grant_lock_fsm,
// checked every cycle against a behavioural model of ownership.
module tb_grant_lock_fsm;
    import grant_pkg::*;

    localparam int MAX_HOLD   = 8;
    localparam int GAP_CYCLES = 1;

    logic clk;
    logic rst;

    grant_lock_fsm_if bus ();

    grant_lock_fsm #(
        .MAX_HOLD   (MAX_HOLD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Model: who owns the grant (0 = nobody, else requester index + 1), how
    // many cycles the grant has been visible, and how many dead cycles remain.
    int m_owner;
    int m_held;
    int m_dead;
    int m_tp;
    int m_count;

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_dead  = 0;
        m_tp    = 0;
        m_count = 0;
    endtask

    task automatic model_edge();
        int gc;
        gc   = int'(bus.grant_code);
        m_tp = 0;
        if (m_owner != 0) begin
            if (bus.request[m_owner-1] == 1'b0) begin
                m_owner = 0;
                m_dead  = GAP_CYCLES;
            end else if (m_held >= MAX_HOLD) begin
                m_owner = 0;
                m_dead  = GAP_CYCLES;
                m_tp    = 1;
            end else begin
                m_held++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (gc != 0) begin
            m_owner = gc;
            m_held  = 1;
            if (m_count < 255) m_count++;
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int exp_gnt;
        exp_gnt = (m_owner == 0) ? 0 : (1 << (m_owner - 1));
        check("gnt_onehot", int'(bus.gnt_onehot), exp_gnt);
        check("owner", int'(bus.owner), m_owner);
        check("busy", int'(bus.busy), (m_owner != 0 || m_dead > 0) ? 1 : 0);
        check("timeout_pulse", int'(bus.timeout_pulse), m_tp);
        check("grants_total", int'(bus.grants_total), m_count);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [2:0] req, input logic [1:0] gc);
        bus.request    = req;
        bus.grant_code = gc;
    endtask

    function automatic logic [1:0] encode(input logic [2:0] req);
        if (req[0]) return 2'b01;
        if (req[1]) return 2'b10;
        if (req[2]) return 2'b11;
        return 2'b00;
    endfunction

    initial begin
        int ghigh;
        int tp_seen;
        logic [2:0] rreq;

        total = 0;
        bad   = 0;
        model_reset();
        rst = 1'b1;
        drive(3'b000, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", int'(bus.gnt_onehot), 0);
        check("rst_owner", int'(bus.owner), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_tp", int'(bus.timeout_pulse), 0);
        check("rst_total", int'(bus.grants_total), 0);
        #3;
        rst = 1'b0;

        // Single grant and release after three granted cycles.
        drive(3'b001, 2'b01);
        repeat (3) step();
        check("single_gnt", int'(bus.gnt_onehot), 3'b001);
        drive(3'b000, 2'b00);
        step();
        check("single_gap_busy", int'(bus.busy), 1);
        step();
        check("single_total", int'(bus.grants_total), 1);

        // Timeout: grant visible for exactly MAX_HOLD cycles, one pulse.
        drive(3'b100, 2'b11);
        ghigh   = 0;
        tp_seen = 0;
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            step();
            if (bus.gnt_onehot == 3'b100) ghigh++;
            if (bus.timeout_pulse) begin
                tp_seen = 1;
                break;
            end
        end
        check("timeout_seen", tp_seen, 1);
        check("timeout_hold_len", ghigh, MAX_HOLD);
        step();
        check("timeout_tp_clear", int'(bus.timeout_pulse), 0);
        step();
        check("timeout_regrant", int'(bus.gnt_onehot), 3'b100);
        check("timeout_total", int'(bus.grants_total), 3);
        drive(3'b000, 2'b00);
        repeat (2) step();

        // Lock stability: req1 owns, encoder switches to req0 mid-grant.
        drive(3'b010, 2'b10);
        step();
        drive(3'b011, 2'b01);
        repeat (3) step();
        check("lock_hold", int'(bus.gnt_onehot), 3'b010);
        drive(3'b001, 2'b01);
        step();
        check("lock_release", int'(bus.gnt_onehot), 3'b000);
        step();
        step();
        check("lock_next", int'(bus.gnt_onehot), 3'b001);
        drive(3'b000, 2'b00);
        repeat (2) step();

        // Release on the same edge the hold limit would fire.
        drive(3'b010, 2'b10);
        repeat (MAX_HOLD) step();
        drive(3'b000, 2'b00);
        step();
        check("simul_no_tp", int'(bus.timeout_pulse), 0);
        check("simul_gap", int'(bus.busy), 1);
        step();

        // Asynchronous reset between edges while req1 owns.
        drive(3'b010, 2'b10);
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_gnt", int'(bus.gnt_onehot), 0);
        check("arst_owner", int'(bus.owner), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_total", int'(bus.grants_total), 0);
        drive(3'b000, 2'b00);
        #2;
        rst = 1'b0;

        // Saturation of the grant counter.
        for (int i = 0; i < 300; i++) begin
            drive(3'b001, 2'b01);
            step();
            drive(3'b000, 2'b00);
            repeat (2) step();
        end
        check("sat_total", int'(bus.grants_total), 255);

        // Random traffic, mostly consistent encoder output, some inconsistent.
        for (int i = 0; i < 2000; i++) begin
            rreq = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) drive(rreq, encode(rreq));
            else drive(rreq, 2'($urandom_range(0, 3)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grant_lock_fsm.md
Name: grant_lock_fsm

Overview:
- Sequential stage directly downstream of the 3-requester fixed-priority encoder; consumes its 2-bit grant code (00 none, 01 req0, 10 req1, 11 req2).
- Registers the code, locks ownership to one requester and drives a registered one-hot grant.
- Holds the grant until the owner drops its request or a hold timeout expires, then inserts dead cycles before re-arbitrating.
- Prevents the combinational encoder output from glitching ownership between cycles.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles gnt_onehot may stay asserted for one owner (>=1).
- GAP_CYCLES, 1, dead cycles with no grant after each release or timeout (>=1).
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- grant_code  input  2  encoded grant from the priority encoder; sampled only in IDLE.
- request  input  3  raw request vector, same one feeding the encoder; used for release detection.
- gnt_onehot  output  3  registered one-hot grant to the owner.
- owner  output  2  registered code of the current owner; 00 when none.
- busy  output  1  high in OWN or GAP.
- timeout_pulse  output  1  single-cycle pulse when a grant is revoked by timeout.
- grants_total  output  8  saturating count of grants issued.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt_onehot=000, owner=00, busy=0, timeout_pulse=0, grants_total=0, hold_cnt=0, gap_cnt=0. Reset mid-grant drops gnt_onehot in the same cycle, without waiting for a clock edge.
- All outputs are registered. busy is decoded from the state register.
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - grant_code != 00 at a clock edge -> OWN.
  - At that edge: owner<=grant_code, gnt_onehot<=decode(grant_code) (01->001, 10->010, 11->100), hold_cnt<=0, grants_total++ (saturates at 255).
  - Latency from grant_code valid to gnt_onehot: 1 cycle.
  - grant_code==00 -> remain in IDLE.
- OWN:
  - grant_code is ignored.
  - Each edge, the first matching rule applies:
    - request[owner-1]==0 -> GAP. gnt_onehot<=0, owner<=0, gap_cnt<=0. No timeout pulse.
    - Otherwise hold_cnt==MAX_HOLD-1 -> GAP. gnt_onehot<=0, owner<=0, gap_cnt<=0, timeout_pulse<=1.
    - Otherwise hold_cnt++.
  - gnt_onehot is therefore high for at most MAX_HOLD cycles.
  - Release and timeout in the same cycle: release wins, timeout_pulse stays 0.
  - Changes on non-owner request bits have no effect.
- GAP:
  - gnt_onehot=000.
  - gap_cnt increments; at gap_cnt==GAP_CYCLES-1 -> IDLE.
  - timeout_pulse clears one cycle after being set.
- Re-arbitration happens only from IDLE. A timed-out owner that still requests may win again if the encoder selects it; fairness is out of scope for this block.
- Inconsistent input: grant_code!=00 in IDLE while request[code-1]==0. The block still grants, and releases on the next OWN edge (1-cycle grant).
- Counter widths: hold_cnt is CNT_W bits, gap_cnt is $clog2(GAP_CYCLES+1) bits, and neither wraps within legal operation. grants_total holds at 8'hFF.

Decomposition:
- Package grant_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN, GAP} lock_state_t
  - typedef logic [1:0] grant_code_t
  - constant GC_NONE=2'b00
  - function code2onehot(grant_code_t) returning logic [2:0]
- One natural sub-module: sat_counter (parameterised width, increment enable, saturate flag), instantiated for grants_total.
- FSM and hold/gap counters stay in grant_lock_fsm.

Test Plan:
- Single grant and release:
  - Stimulus: request=001 and grant_code=01 from t0; request drops to 000 after 3 cycles.
  - Response: gnt_onehot=001 on the cycle after t0 for 3 cycles, then 000; busy high through one GAP cycle; grants_total=1; timeout_pulse stays 0.
- Timeout (MAX_HOLD=8):
  - Stimulus: request=100 and grant_code=11 held.
  - Response: gnt_onehot=100 for exactly 8 cycles; timeout_pulse=1 for one cycle at revocation; after 1 GAP cycle, regrant with gnt_onehot=100; grants_total=2.
- Lock stability:
  - Stimulus: owner is req1 (gnt_onehot=010); request changes to 011 and grant_code to 01 mid-grant.
  - Response: gnt_onehot stays 010 until request[1]=0; req0 is granted only after GAP.
- Simultaneous release and timeout:
  - Stimulus: request[owner] drops on the cycle hold_cnt==7.
  - Response: GAP is entered, timeout_pulse stays 0.
- Async reset mid-OWN:
  - Stimulus: rst pulsed between clock edges while gnt_onehot=010.
  - Response: gnt_onehot=000, owner=00, busy=0 immediately; grants_total=0.
- Saturation:
  - Stimulus: 300 grant/release cycles.
  - Response: grants_total=255 and holds.
